// File: rtl/reg_file_mp.sv
// Parametrised NREAD x NWRITE register file with clear sweep and ready flag.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear_req,
    output logic                           ready,
    input  logic [NWRITE-1:0]              wr_en,
    input  logic [NWRITE*$clog2(NREGS)-1:0] waddr,
    input  logic [NWRITE*XLEN-1:0]         wdata,
    input  logic [NREAD*$clog2(NREGS)-1:0]  raddr,
    output logic [NREAD*XLEN-1:0]          rdata
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] mem [NREGS];
    logic [NWRITE-1:0] wr_ok;
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    // Writes to a hardwired zero register are dropped here once.
    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < NWRITE; k++) begin
            wr_ok[k] = wr_en[k] &&
                !(ZERO_REG != 0 && waddr[k*AW +: AW] == '0);
        end
    end

    // Ascending port loop: the highest-index port lands last and wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    mem[clr_cnt] <= '0;
                    if (clr_cnt == AW'(NREGS - 1)) begin
                        state   <= READY;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    for (int k = 0; k < NWRITE; k++) begin
                        if (wr_ok[k]) begin
                            mem[waddr[k*AW +: AW]] <=
                                wdata[k*XLEN +: XLEN];
                        end
                    end
                    if (clear_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    assign ready = (state == READY);

    always_comb begin
        rdata = '0;
        ra    = '0;
        rv    = '0;
        for (int j = 0; j < NREAD; j++) begin
            ra = raddr[j*AW +: AW];
            rv = mem[ra];
            if (ZERO_REG != 0 && ra == '0) begin
                rv = '0;
            end
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_ok[k] && waddr[k*AW +: AW] == ra) begin
                    rv = wdata[k*XLEN +: XLEN];
                end
            end
`endif
            // Contents are undefined until swept, so mask during CLEAR.
            if (state != READY) begin
                rv = '0;
            end
            rdata[j*XLEN +: XLEN] = rv;
        end
    end

endmodule
